// File: rtl/ca_pipe_pkg.sv
// Shared pipeline constants: control bundle layout, NOP encoding and ALUOp codes.
// Imported by the ID/EX stage and its hazard detector.
package ca_pipe_pkg;

  localparam int CTRL_W   = 8;

  // Control bundle bit positions {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,ALUOp[1:0],RegDst}
  localparam int REGWRITE = 7;
  localparam int MEMTOREG = 6;
  localparam int MEMREAD  = 5;
  localparam int MEMWRITE = 4;
  localparam int ALUSRC   = 3;
  localparam int ALUOP_HI = 2;
  localparam int ALUOP_LO = 1;
  localparam int REGDST   = 0;

  localparam logic [7:0] CTRL_NOP = 8'h00;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: compares the EX-stage load destination with the ID sources.
// Purely combinational, zero latency; no flow control of its own.
module hazard_detect
  import ca_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt_addr,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  output logic              hazard
);

  logic dst_nonzero;
  logic src_match;

  // $0 is hard-wired, so a load targeting it can never create a real dependency
  assign dst_nonzero = (ex_rt_addr != '0);
  assign src_match   = (ex_rt_addr == id_rs_addr) | (ex_rt_addr == id_rt_addr);
  assign hazard      = ex_mem_read & dst_nonzero & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion; 1-cycle latency; hold_i freezes all state.
// Stalls upstream via pc_write_o/ifid_write_o. Optional ID_EX_BUBBLE_CNT_EN adds bubble_cnt_o.
module id_ex_stage
  import ca_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = ca_pipe_pkg::CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rs_addr_o,
  output logic [REG_AW-1:0] rt_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              hazard_o,
  output logic              pc_write_o,
  output logic              ifid_write_o
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt_o
`endif
);

  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

  logic bubble;
  logic stall_n;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .ex_mem_read (ctrl_o[MEMREAD]),
    .ex_rt_addr  (rt_addr_o),
    .id_rs_addr  (rs_addr_i),
    .id_rt_addr  (rt_addr_i),
    .hazard      (hazard_o)
  );

  // A flush coinciding with a hazard still yields exactly one bubble
  assign bubble       = flush_i | hazard_o;
  assign stall_n      = ~hazard_o & ~hold_i;
  assign pc_write_o   = stall_n;
  assign ifid_write_o = stall_n;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_o    <= NOP;
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
      rs_addr_o <= '0;
      rt_addr_o <= '0;
      rd_addr_o <= '0;
    end else if (!hold_i) begin
      ctrl_o    <= bubble ? NOP : ctrl_i;
      rs_data_o <= rs_data_i;
      rt_data_o <= rt_data_i;
      imm_o     <= imm_i;
      rs_addr_o <= rs_addr_i;
      rt_addr_o <= rt_addr_i;
      rd_addr_o <= rd_addr_i;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
    end else if (!hold_i && bubble && (bubble_cnt_o != 16'hFFFF)) begin
      bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end
  end
`endif

endmodule
